// File: rtl/q_timing_pkg.sv
// q_timing_pkg: shared FSM states, queue entry layout and default widths for q_timing_queue.
package q_timing_pkg;
    localparam int TQ_DEPTH  = 16;
    localparam int TQ_TS_W   = 32;
    localparam int TQ_INST_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} tq_state_e;
    typedef struct packed {
        logic [TQ_TS_W-1:0]   ts;
        logic [TQ_INST_W-1:0] inst;
    } tq_entry_t;
endpackage

// File: rtl/tq_fifo.sv
// tq_fifo: synchronous DEPTH-entry FIFO; extra pointer MSB tells full from empty.
module tq_fifo
    import q_timing_pkg::*;
#(
    parameter int DEPTH = TQ_DEPTH,
    parameter int W     = $bits(tq_entry_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp, r_rp;
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_rdata = r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_wr) r_wp <= r_wp + (AW+1)'(1);
            if (i_rd) r_rp <= r_rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (i_wr) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/q_timing_queue.sv
// q_timing_queue: timestamped quantum-op queue released by a free-running issue timer.
// Define TQ_LATE_DROP_EN to discard late entries instead of issuing them.
module q_timing_queue
    import q_timing_pkg::*;
#(
    parameter int DEPTH  = TQ_DEPTH,
    parameter int TS_W   = TQ_TS_W,
    parameter int INST_W = TQ_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inst_valid,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_time_write,
    input  logic              i_time_sel,
    input  logic [TS_W-1:0]   i_time_val,
    input  logic              i_run,
    input  logic              i_end,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_evt_valid,
    output logic [INST_W-1:0] o_evt_inst,
    output logic [TS_W-1:0]   o_evt_ts,
    output logic [TS_W-1:0]   o_timer,
    output logic              o_overflow,
    output logic              o_late,
    output logic              o_done
);
    tq_state_e         r_state, w_state_nx;
    logic [TS_W-1:0]   r_timer, r_timeline, w_head_ts, w_d;
    logic [INST_W-1:0] w_head_inst;
    logic              w_active, w_push, w_pop, w_late, w_issue;
    assign w_active = (r_state == RUN) || (r_state == DRAIN);
    // signed distance to the head stamp keeps the compare safe across timer wrap
    assign w_d      = w_head_ts - r_timer;
    assign w_late   = w_d[TS_W-1];
    assign w_pop    = w_active && !o_empty && (w_late || w_d == '0);
    assign w_push   = i_inst_valid && (r_state != DONE);
`ifdef TQ_LATE_DROP_EN
    assign w_issue  = w_pop && !w_late;
`else
    assign w_issue  = w_pop;
`endif
    assign o_timer  = r_timer;
    assign o_done   = r_state == DONE;
    tq_fifo #(.DEPTH(DEPTH), .W(TS_W + INST_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_push && (!o_full || w_pop)),
        .i_wdata ({r_timeline, i_inst}),
        .i_rd    (w_pop),
        .o_rdata ({w_head_ts, w_head_inst}),
        .o_full  (o_full),
        .o_empty (o_empty)
    );
    always_comb begin
        w_state_nx = r_state;
        w_state_nx = (r_state == IDLE && i_run)     ? RUN   :
                     (r_state == RUN && i_end)      ? DRAIN :
                     (r_state == DRAIN && o_empty)  ? DONE  : r_state;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_timeline  <= '0;
            o_evt_valid <= 1'b0;
            o_evt_inst  <= '0;
            o_evt_ts    <= '0;
            o_overflow  <= 1'b0;
            o_late      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            o_evt_valid <= w_issue;
            if (w_active) r_timer <= r_timer + TS_W'(1);
            if (i_time_write && r_state != DONE)
                r_timeline <= i_time_sel ? i_time_val : r_timeline + i_time_val;
            if (w_issue) begin
                o_evt_inst <= w_head_inst;
                o_evt_ts   <= w_head_ts;
            end
            if (w_push && o_full && !w_pop) o_overflow <= 1'b1;
            if (w_pop && w_late) o_late <= 1'b1;
        end
    end
endmodule

// File: doc/q_timing_queue.md
Name: q_timing_queue

Overview:
Timestamped quantum-operation queue directly downstream of classical_ctrl's quantum interface.
- Captures q_inst issued by classical_ctrl (q_rot / q_slm pulses) and stamps each with the current timeline value.
- The timeline is advanced by QWAIT-style q_time_write / q_time_sel / q_time_reg updates.
- Releases each operation to the analog/pulse back-end when a free-running issue timer reaches its stamp, decoupling non-deterministic classical execution from deterministic quantum timing.

Parameters:
DEPTH, 16, queue entries (power of 2, ≥4)
TS_W, 32, timestamp/timer width
INST_W, 32, quantum instruction width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
i_inst_valid  in  1  push strobe (q_rot | q_slm from classical_ctrl)
i_inst  in  INST_W  quantum instruction (q_inst)
i_time_write  in  1  timeline update strobe (q_time_write)
i_time_sel  in  1  0: timeline += i_time_val; 1: timeline = i_time_val
i_time_val  in  TS_W  wait/absolute value (q_time_reg)
i_run  in  1  start timer (start_sig[0])
i_end  in  1  program finished (end_sig[0])
o_full  out  1  queue full
o_empty  out  1  queue empty
o_evt_valid  out  1  one-cycle issue pulse
o_evt_inst  out  INST_W  issued instruction
o_evt_ts  out  TS_W  issued entry's timestamp
o_timer  out  TS_W  issue timer
o_overflow  out  1  sticky: push dropped while full
o_late  out  1  sticky: an entry issued after its stamp
o_done  out  1  drained after i_end

Behaviour:
- Reset (rst==0 at posedge): all outputs 0 except o_empty=1. Timeline=0, timer=0, pointers=0, state IDLE.
- States:
  - IDLE: timer held at 0. Go to RUN when i_run=1.
  - RUN: timer += 1 per cycle, wrapping modulo 2^TS_W. Go to DRAIN when i_end=1.
  - DRAIN: timer keeps counting; pushes are still accepted. Go to DONE when the queue is empty and no issue is in this cycle.
  - DONE: o_done=1, timer frozen, everything held until reset.
- Timeline:
  - i_time_write updates the timeline at the posedge.
  - If i_inst_valid is asserted in the same cycle, the pushed entry uses the pre-update timeline.
  - Add wraps modulo 2^TS_W.
- Push:
  - i_inst_valid && !full writes {timeline, i_inst} at the tail; visible to issue logic the next cycle.
  - Push while full: entry dropped, o_overflow set (sticky until reset).
  - Push is accepted in every state except DONE, including IDLE so pre-load is allowed.
- Issue (RUN/DRAIN only, at most one pop per cycle):
  - d = head.ts − timer, taken as a signed TS_W value, so wrap is safe.
  - d>0: wait.
  - d==0: pop; o_evt_valid=1 next cycle with o_evt_inst/o_evt_ts registered. Issue latency is 1 cycle.
  - d<0: pop immediately and set o_late (sticky).
- Entries with equal stamps issue on consecutive cycles; the second and later ones raise o_late.
- Simultaneous push and pop is legal when full: the count stays DEPTH and o_overflow is not set.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB compare.
- o_evt_* hold their last value when o_evt_valid=0.
- Reset mid-operation discards all entries and sticky flags within one cycle.

Optional Feature:
TQ_LATE_DROP_EN
- Defined: entries with d<0 are popped without an o_evt_valid pulse (discarded); o_late is still set.
- Undefined: late entries are issued (o_evt_valid=1) as described above.

Decomposition:
- Package q_timing_pkg:
  - tq_state_e enum {IDLE, RUN, DRAIN, DONE}
  - tq_entry_t struct {ts[TS_W], inst[INST_W]}
  - default width constants
- Sub-module tq_fifo: synchronous DEPTH-entry FIFO with full/empty; single storage array with registered pointers.

Test Plan:
- Reset, push 0xA0000001 with timeline 0 in IDLE, then i_run → o_evt_valid at timer 0 pop, o_evt_inst=0xA0000001, o_late=0.
- QWAIT: i_time_sel=0, i_time_val=15, then push 0xB0000002 → issue when o_timer==15, o_evt_ts=15, no late.
- Absolute set i_time_val=100, push 3 ops with stamps 100,100,105 → issues at timers 100, 101 (o_late=1), 105; with TQ_LATE_DROP_EN the second op is not issued.
- Push 17 entries (DEPTH=16) with timer in IDLE → o_full=1, o_overflow=1, 16 entries issue after i_run.
- Timeline at 0xFFFFFFF0 plus wait 0x20 → stamp 0x10 wraps; the entry issues only after timer wraps to 0x10 and is not flagged late.
- Assert i_end with 2 entries pending → state DRAIN, o_done=1 the cycle after the last pop; rst=0 mid-DRAIN clears o_done, o_empty=1.
